// File: rtl/cpu_ctrl_ws.sv
// Multi-cycle controller for the 16-bit Simple RISC Machine: owns IR, PC and the
// data-address register, sequences the external datapath, and handles memory wait states.
module cpu_ctrl_ws #(
    parameter int unsigned       ADDR_W   = 9,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_ready,
    input  logic [2:0]        flags,
    input  logic [ADDR_W-1:0] dp_out,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [2:0]        mem_cmd,
    output logic [2:0]        readnum,
    output logic [2:0]        writenum,
    output logic [1:0]        vsel,
    output logic              loada,
    output logic              loadb,
    output logic              loadc,
    output logic              loads,
    output logic              asel,
    output logic              bsel,
    output logic              write,
    output logic [1:0]        alu_op,
    output logic [1:0]        shift,
    output logic [15:0]       sximm5,
    output logic [15:0]       sximm8,
    output logic [ADDR_W-1:0] pc_out,
    output logic              halted,
    output logic              err
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_WIMM   = 4'd2;
    localparam logic [3:0] S_GETA   = 4'd3;
    localparam logic [3:0] S_GETB   = 4'd4;
    localparam logic [3:0] S_EXEC   = 4'd5;
    localparam logic [3:0] S_WB     = 4'd6;
    localparam logic [3:0] S_LDADDR = 4'd7;
    localparam logic [3:0] S_MRD    = 4'd8;
    localparam logic [3:0] S_GETD   = 4'd9;
    localparam logic [3:0] S_SPASS  = 4'd10;
    localparam logic [3:0] S_MWR    = 4'd11;
    localparam logic [3:0] S_BRANCH = 4'd12;
    localparam logic [3:0] S_HALT   = 4'd13;
    localparam logic [3:0] S_ERR    = 4'd14;

    localparam logic [2:0] MNONE  = 3'b001;
    localparam logic [2:0] MREAD  = 3'b010;
    localparam logic [2:0] MWRITE = 3'b100;

    localparam int unsigned       WCW      = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WCW-1:0]    WAIT_LIM = WCW'(MAX_WAIT);

    logic [3:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic [ADDR_W-1:0] daddr_q, daddr_d;
    logic [WCW-1:0]    wait_q, wait_d;

    logic [2:0]        opcode;
    logic [1:0]        op;
    logic [2:0]        rn, rd, rm, cond;
    logic              fl_n, fl_v, fl_z;
    logic              taken;
    logic              mem_state;
    logic              timeout;
    logic [ADDR_W-1:0] br_off;

    assign opcode = ir_q[15:13];
    assign op     = ir_q[12:11];
    assign rn     = ir_q[10:8];
    assign rd     = ir_q[7:5];
    assign rm     = ir_q[2:0];
    assign cond   = ir_q[10:8];
    assign fl_n   = flags[2];
    assign fl_v   = flags[1];
    assign fl_z   = flags[0];

    assign sximm5 = {{11{ir_q[4]}}, ir_q[4:0]};
    assign sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};
    assign br_off = ADDR_W'({{ADDR_W{ir_q[7]}}, ir_q[7:0]});
    assign alu_op = op;
    assign pc_out = pc_q;
    assign halted = (state_q == S_HALT);
    assign err    = (state_q == S_ERR);

    always_comb begin
        case (cond)
            3'b000:  taken = 1'b1;
            3'b001:  taken = fl_z;
            3'b010:  taken = !fl_z;
            3'b011:  taken = (fl_n != fl_v);
            3'b100:  taken = (fl_n != fl_v) || fl_z;
            default: taken = 1'b0;
        endcase
    end

    assign mem_state = (state_q == S_FETCH) || (state_q == S_MRD) || (state_q == S_MWR);
    // The limit check uses the registered count, so a ready on the limit cycle still completes.
    assign timeout   = (MAX_WAIT != 0) && mem_state && !mem_ready && (wait_q == WAIT_LIM);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        daddr_d = daddr_q;
        wait_d  = (mem_state && !mem_ready) ? wait_q + WCW'(1) : '0;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d = S_ERR;
                end
            end
            S_DECODE: begin
                case (opcode)
                    3'b110: begin
                        if (op == 2'b10)      state_d = S_WIMM;
                        else if (op == 2'b00) state_d = S_GETA;
                        else                  state_d = S_FETCH;
                    end
                    3'b111:                   state_d = S_HALT;
                    3'b001:                   state_d = taken ? S_BRANCH : S_FETCH;
                    3'b011, 3'b100, 3'b101:   state_d = S_GETA;
                    default:                  state_d = S_FETCH;
                endcase
            end
            S_WIMM:   state_d = S_FETCH;
            S_GETA:   state_d = (opcode == 3'b011 || opcode == 3'b100) ? S_EXEC : S_GETB;
            S_GETB:   state_d = S_EXEC;
            S_EXEC: begin
                if (opcode == 3'b101 && op == 2'b01)         state_d = S_FETCH;
                else if (opcode == 3'b011 || opcode == 3'b100) state_d = S_LDADDR;
                else                                         state_d = S_WB;
            end
            S_WB:     state_d = S_FETCH;
            S_LDADDR: begin
                daddr_d = dp_out;
                state_d = (opcode == 3'b011) ? S_MRD : S_GETD;
            end
            S_MRD, S_MWR: begin
                if (mem_ready)    state_d = S_FETCH;
                else if (timeout) state_d = S_ERR;
            end
            S_GETD:   state_d = S_SPASS;
            S_SPASS:  state_d = S_MWR;
            S_BRANCH: begin
                pc_d    = pc_q + br_off;
                state_d = S_FETCH;
            end
            S_HALT, S_ERR: state_d = state_q;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        mem_cmd  = MNONE;
        mem_addr = daddr_q;
        readnum  = 3'b000;
        writenum = 3'b000;
        vsel     = 2'b00;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        write    = 1'b0;
        shift    = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_cmd  = MREAD;
                mem_addr = pc_q;
            end
            S_WIMM: begin
                vsel     = 2'b10;
                writenum = rn;
                write    = 1'b1;
            end
            S_GETA: begin
                readnum = rn;
                loada   = 1'b1;
            end
            S_GETB: begin
                readnum = rm;
                loadb   = 1'b1;
            end
            S_EXEC: begin
                loadc = 1'b1;
                loads = (opcode == 3'b101);
                asel  = (opcode == 3'b110) && (op == 2'b00);
                bsel  = (opcode == 3'b011) || (opcode == 3'b100);
                if (opcode == 3'b101 || (opcode == 3'b110 && op == 2'b00))
                    shift = ir_q[4:3];
            end
            S_WB: begin
                writenum = rd;
                write    = 1'b1;
            end
            S_MRD: begin
                mem_cmd  = MREAD;
                vsel     = 2'b11;
                writenum = rd;
                write    = mem_ready;
            end
            S_GETD: begin
                readnum = rd;
                loadb   = 1'b1;
            end
            S_SPASS: begin
                asel  = 1'b1;
                loadc = 1'b1;
            end
            S_MWR:   mem_cmd = MWRITE;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            daddr_q <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            daddr_q <= daddr_d;
            wait_q  <= wait_d;
        end
    end

endmodule

// File: tb/tb_cpu_ctrl_ws.sv
// Bench for cpu_ctrl_ws: a small behavioural datapath and memory around the controller,
// a table of single-instruction timing vectors, and hand-written multi-cycle sequences.
module tb_cpu_ctrl_ws;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rdy = 1'b1;
    logic        force_en = 1'b0;
    logic [2:0]  fflags = 3'b000;

    logic [15:0] mem [256];
    logic [15:0] mem_rdata;
    logic [2:0]  flags;
    logic [8:0]  dp_out;
    logic [8:0]  mem_addr, pc_out;
    logic [2:0]  mem_cmd, readnum, writenum;
    logic [1:0]  vsel, alu_op, shift;
    logic        loada, loadb, loadc, loads, asel, bsel, write, halted, err;
    logic [15:0] sximm5, sximm8;

    logic [11:0] mem_addr2, pc_out2, dp_out2;
    logic [2:0]  mem_cmd2, readnum2, writenum2, flags2;
    logic [1:0]  vsel2, alu_op2, shift2;
    logic        loada2, loadb2, loadc2, loads2, asel2, bsel2, write2, halted2, err2;
    logic [15:0] sximm5_2, sximm8_2, rdata2;

    logic [15:0] R [8];
    logic [15:0] A, B, C;
    logic [2:0]  stat;
    logic [15:0] sout, ain, bin, res, wdata;
    logic        ovf;

    int unsigned pass_cnt = 0;
    int unsigned tot_cnt = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[7:0]];
    assign flags     = force_en ? fflags : stat;
    assign dp_out    = C[8:0];
    assign dp_out2   = 12'h000;
    assign flags2    = 3'b000;
    assign rdata2    = 16'h0000;

    cpu_ctrl_ws dut (
        .clk(clk), .reset(reset), .mem_rdata(mem_rdata), .mem_ready(rdy), .flags(flags),
        .dp_out(dp_out), .mem_addr(mem_addr), .mem_cmd(mem_cmd), .readnum(readnum),
        .writenum(writenum), .vsel(vsel), .loada(loada), .loadb(loadb), .loadc(loadc),
        .loads(loads), .asel(asel), .bsel(bsel), .write(write), .alu_op(alu_op),
        .shift(shift), .sximm5(sximm5), .sximm8(sximm8), .pc_out(pc_out),
        .halted(halted), .err(err)
    );

    cpu_ctrl_ws #(.ADDR_W(12), .RESET_PC(12'hFFF), .MAX_WAIT(15)) dut2 (
        .clk(clk), .reset(reset), .mem_rdata(rdata2), .mem_ready(1'b1), .flags(flags2),
        .dp_out(dp_out2), .mem_addr(mem_addr2), .mem_cmd(mem_cmd2), .readnum(readnum2),
        .writenum(writenum2), .vsel(vsel2), .loada(loada2), .loadb(loadb2), .loadc(loadc2),
        .loads(loads2), .asel(asel2), .bsel(bsel2), .write(write2), .alu_op(alu_op2),
        .shift(shift2), .sximm5(sximm5_2), .sximm8(sximm8_2), .pc_out(pc_out2),
        .halted(halted2), .err(err2)
    );

    // Datapath model: shifter, ALU with overflow, register-file writeback mux.
    always_comb begin
        sout = B;
        ain  = asel ? 16'h0000 : A;
        res  = 16'h0000;
        ovf  = 1'b0;
        case (shift)
            2'b01:   sout = {B[14:0], 1'b0};
            2'b10:   sout = {1'b0, B[15:1]};
            2'b11:   sout = {B[15], B[15:1]};
            default: sout = B;
        endcase
        bin = bsel ? sximm5 : sout;
        case (alu_op)
            2'b00: begin
                res = ain + bin;
                ovf = (ain[15] == bin[15]) && (res[15] != ain[15]);
            end
            2'b01: begin
                res = ain - bin;
                ovf = (ain[15] != bin[15]) && (res[15] != ain[15]);
            end
            2'b10:   res = ain & bin;
            default: res = ~bin;
        endcase
        case (vsel)
            2'b00:   wdata = C;
            2'b01:   wdata = {7'b0, pc_out};
            2'b10:   wdata = sximm8;
            default: wdata = mem_rdata;
        endcase
    end

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) R[i] <= 16'h0000;
            A    <= 16'h0000;
            B    <= 16'h0000;
            C    <= 16'h0000;
            stat <= 3'b000;
        end else begin
            if (write) R[writenum] <= wdata;
            if (loada) A <= R[readnum];
            if (loadb) B <= R[readnum];
            if (loadc) C <= res;
            if (loads) stat <= {res[15], ovf, (res == 16'h0000)};
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // One clock; a store completing this cycle is committed to memory first.
    task automatic step();
        if (mem_cmd == 3'b100 && rdy) mem[mem_addr[7:0]] = C;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    endtask

    task automatic run_to_halt(input int unsigned limit, output int unsigned n);
        n = 0;
        while (!halted && n < limit) begin
            step();
            n++;
        end
    endtask

    typedef struct {
        logic [15:0] instr;
        logic [2:0]  flg;
        int unsigned cyc;
        logic [8:0]  pc;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    initial begin
        int unsigned n, rd_cnt, wr_cnt, st_cnt, nxt;
        logic [8:0]  st_addr;
        logic        seen10, got;
        logic [15:0] br_instr [2];
        logic [8:0]  br_next [2];
        logic [8:0]  br_pc [2];

        // {instruction at 0, forced {N,V,Z}, cycles incl. fetch, PC once halted}
        vecs[0]  = '{16'hD207, 3'b000, 3, 9'd2};  // MOV R2,#7
        vecs[1]  = '{16'hA041, 3'b000, 6, 9'd2};  // ADD R2,R0,R1
        vecs[2]  = '{16'hA801, 3'b000, 5, 9'd2};  // CMP R0,R1
        vecs[3]  = '{16'h6062, 3'b000, 6, 9'd2};  // LDR R3,[R0,#2]
        vecs[4]  = '{16'h8023, 3'b000, 8, 9'd2};  // STR R1,[R0,#3]
        vecs[5]  = '{16'hC061, 3'b000, 6, 9'd2};  // MOV R3,R1
        vecs[6]  = '{16'hB881, 3'b000, 6, 9'd2};  // MVN R4,R1
        vecs[7]  = '{16'h0000, 3'b000, 2, 9'd2};  // undefined 000
        vecs[8]  = '{16'hC800, 3'b000, 2, 9'd2};  // undefined 110/01
        vecs[9]  = '{16'h2004, 3'b000, 3, 9'd6};  // B
        vecs[10] = '{16'h2104, 3'b001, 3, 9'd6};  // BEQ, Z
        vecs[11] = '{16'h2104, 3'b000, 2, 9'd2};  // BEQ, !Z
        vecs[12] = '{16'h2204, 3'b000, 3, 9'd6};  // BNE, !Z
        vecs[13] = '{16'h2204, 3'b001, 2, 9'd2};  // BNE, Z
        vecs[14] = '{16'h2304, 3'b100, 3, 9'd6};  // BLT, N!=V
        vecs[15] = '{16'h2304, 3'b110, 2, 9'd2};  // BLT, N==V
        vecs[16] = '{16'h2404, 3'b001, 3, 9'd6};  // BLE, Z
        vecs[17] = '{16'h2404, 3'b110, 2, 9'd2};  // BLE, N==V !Z
        vecs[18] = '{16'h2504, 3'b111, 2, 9'd2};  // cond 101 never
        vecs[19] = '{16'h2404, 3'b010, 3, 9'd6};  // BLE, N!=V

        // Reset state, and the wide-address instance wrapping from 0xFFF.
        clear_mem();
        do_reset();
        chk("rst_pc", pc_out, 9'd0);
        chk("rst_cmd", mem_cmd, 3'b010);
        chk("rst_addr", mem_addr, 9'd0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("w12_first_addr", mem_addr2, 12'hFFF);
        chk("w12_first_cmd", mem_cmd2, 3'b010);
        step();
        chk("w12_pc_wrap", pc_out2, 12'h000);
        chk("w12_decode_cmd", mem_cmd2, 3'b001);
        step();
        chk("w12_second_addr", mem_addr2, 12'h000);
        chk("w12_second_cmd", mem_cmd2, 3'b010);

        // Single-instruction timing table, followed by HALT at 1 and at the branch target 5.
        force_en = 1'b1;
        for (int i = 0; i < NV; i++) begin
            clear_mem();
            mem[0] = vecs[i].instr;
            mem[1] = 16'hE000;
            mem[5] = 16'hE000;
            fflags = vecs[i].flg;
            rdy = 1'b1;
            do_reset();
            run_to_halt(30, n);
            chk($sformatf("vec%0d_cycles", i), n, vecs[i].cyc + 2);
            chk($sformatf("vec%0d_pc", i), pc_out, vecs[i].pc);
        end
        force_en = 1'b0;

        // MOV R0,#5; MOV R1,#3; ADD R2,R0,R1; HALT
        clear_mem();
        mem[0] = 16'hD005; mem[1] = 16'hD103; mem[2] = 16'hA041; mem[3] = 16'hE000;
        do_reset();
        repeat (13) step();
        chk("prog_halted_c14", halted, 1'b0);
        step();
        chk("prog_halted_c15", halted, 1'b1);
        chk("prog_pc", pc_out, 9'd4);
        chk("prog_r2", R[2], 16'd8);

        // LDR R3,[R0,#2] with three wait cycles in MRD.
        clear_mem();
        mem[0] = 16'hD005; mem[1] = 16'h6062; mem[2] = 16'hE000; mem[7] = 16'hBEEF;
        do_reset();
        rd_cnt = 0; wr_cnt = 0; n = 0;
        while (!halted && n < 60) begin
            if (mem_cmd == 3'b010 && mem_addr == 9'd7) begin
                rd_cnt++;
                rdy = (rd_cnt > 3);
            end else begin
                rdy = 1'b1;
            end
            #1;
            if (write && vsel == 2'b11) wr_cnt++;
            step();
            n++;
        end
        rdy = 1'b1;
        chk("ldr_read_cycles", rd_cnt, 4);
        chk("ldr_write_pulses", wr_cnt, 1);
        chk("ldr_r3", R[3], 16'hBEEF);
        chk("ldr_err", err, 1'b0);

        // STR R1,[R0,#1]
        clear_mem();
        mem[0] = 16'hD005; mem[1] = 16'hD103; mem[2] = 16'h8021; mem[3] = 16'hE000;
        do_reset();
        st_cnt = 0; st_addr = '0; n = 0;
        while (!halted && n < 60) begin
            if (mem_cmd == 3'b100) begin
                st_cnt++;
                st_addr = mem_addr;
            end
            step();
            n++;
        end
        chk("str_cycles", st_cnt, 1);
        chk("str_addr", st_addr, 9'd6);
        chk("str_mem6", mem[6], 16'd3);
        chk("str_halted", halted, 1'b1);

        // CMP R0,R0 at 9, then BEQ/BNE #-3 at 10; HALT at 8 and 11.
        br_instr[0] = 16'h21FD; br_next[0] = 9'd8;  br_pc[0] = 9'd9;
        br_instr[1] = 16'h22FD; br_next[1] = 9'd11; br_pc[1] = 9'd12;
        for (int k = 0; k < 2; k++) begin
            clear_mem();
            mem[0] = 16'hD005; mem[1] = 16'h2007; mem[8] = 16'hE000;
            mem[9] = 16'hA800; mem[10] = br_instr[k]; mem[11] = 16'hE000;
            do_reset();
            seen10 = 1'b0; got = 1'b0; nxt = 0; n = 0;
            while (!halted && n < 60) begin
                if (mem_cmd == 3'b010) begin
                    if (seen10 && !got) begin
                        nxt = mem_addr;
                        got = 1'b1;
                    end
                    if (mem_addr == 9'd10) seen10 = 1'b1;
                end
                step();
                n++;
            end
            chk($sformatf("br%0d_next_fetch", k), nxt, br_next[k]);
            chk($sformatf("br%0d_pc", k), pc_out, br_pc[k]);
        end

        // Fetch timeout, stickiness, reset recovery, and ready on the limit cycle.
        clear_mem();
        mem[0] = 16'hE000;
        rdy = 1'b0;
        do_reset();
        repeat (15) step();
        chk("to_err_before", err, 1'b0);
        step();
        chk("to_err_after", err, 1'b1);
        chk("to_pc", pc_out, 9'd0);
        chk("to_cmd", mem_cmd, 3'b001);
        rdy = 1'b1;
        repeat (3) step();
        chk("to_err_sticky", err, 1'b1);
        chk("to_pc_frozen", pc_out, 9'd0);
        do_reset();
        chk("to_rst_err", err, 1'b0);
        chk("to_rst_pc", pc_out, 9'd0);
        rdy = 1'b0;
        repeat (15) step();
        rdy = 1'b1;
        step();
        chk("lim_ready_err", err, 1'b0);
        chk("lim_ready_pc", pc_out, 9'd1);
        run_to_halt(10, n);
        chk("lim_ready_halted", halted, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
